cpu: RTL and testbench



---
 rtl/cpu.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_cpu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Five-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with on-chip IMEM/DMEM.
// IMEM is loaded through a serial write port; results are observed via internal state.

module instr_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_data
);
    logic [31:0] cache_c [0:255];
    logic [7:0]  wptr;

    // Contents survive reset; only the load pointer is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= 8'd0;
        end else if (wr_en) begin
            wptr <= wptr + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            cache_c[wptr] <= wr_data;
        end
    end

    assign rd_data = cache_c[rd_addr];
endmodule

module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] instr_o,
    output logic [31:0] fetch_pc
);
    logic [31:0] pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;
        end else if (redirect) begin
            pc <= target & 32'h0000_03ff;
        end else if (!stall) begin
            pc <= (pc + 32'd4) & 32'h0000_03ff;
        end
    end

    instr_cache instr_cache (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_addr (pc[9:2]),
        .rd_data (instr_o)
    );

    assign fetch_pc = pc;
endmodule

module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] instr_r;
    logic [31:0] pc_r;
    logic [31:0] regs [0:31];
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_r <= NOP;
            pc_r    <= 32'd0;
        end else if (!stall) begin
            instr_r <= fetch_instr;
            pc_r    <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign rs1 = instr_r[19:15];
    assign rs2 = instr_r[24:20];

    // Write-first: a write-back in this cycle is visible to the read.
    always_comb begin
        rs1_data = regs[rs1];
        if (rs1 == 5'd0) begin
            rs1_data = 32'd0;
        end else if (wb_en && wb_rd == rs1) begin
            rs1_data = wb_data;
        end
        rs2_data = regs[rs2];
        if (rs2 == 5'd0) begin
            rs2_data = 32'd0;
        end else if (wb_en && wb_rd == rs2) begin
            rs2_data = wb_data;
        end
    end

    assign instr = instr_r;
    assign pc    = pc_r;
endmodule

module cpu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_instr_en_i,
    input  logic [31:0] wr_instr_i
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_ALU    = 7'b0110011;
    localparam logic [6:0]  OP_ALU_I  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    function automatic logic is_valid(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            OP_ALU:   return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            OP_ALU_I: return (f3 == 3'b001) ? (f7 == 7'h00)
                           : (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OP_LOAD, OP_STORE: return 1'b1;
            OP_BRANCH: return f3 != 3'b010 && f3 != 3'b011;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [31:0] ins);
        return (ins[6:0] == OP_ALU || ins[6:0] == OP_ALU_I || ins[6:0] == OP_LOAD)
               && ins[11:7] != 5'd0;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP_ALU || op == OP_STORE || op == OP_BRANCH;
    endfunction

    logic [31:0] fetch_instr, fetch_pc;
    logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
    logic [31:0] ex_instr, ex_pc, ex_rs1_data, ex_rs2_data;
    logic [31:0] mem_instr, ex_alu_result, mem_store_data;
    logic [31:0] wb_instr, wb_result;
    logic [31:0] dmem [0:255];
    logic [31:0] load_data;

    logic        load_use, br_taken, br_cond, alu_alt;
    logic [6:0]  ex_op;
    logic [2:0]  ex_f3, alu_f3;
    logic [4:0]  ex_rd;
    logic [31:0] op_a, op_b, alu_b, alu_res, br_target;
    logic [31:0] imm_i, imm_s, imm_b;

    if_stage if_stage (
        .clk      (clk_i),
        .rst      (rst_i),
        .stall    (load_use),
        .redirect (br_taken),
        .target   (br_target),
        .wr_en    (wr_instr_en_i),
        .wr_data  (wr_instr_i),
        .instr_o  (fetch_instr),
        .fetch_pc (fetch_pc)
    );

    id_stage id_stage (
        .clk         (clk_i),
        .rst         (rst_i),
        .stall       (load_use),
        .flush       (br_taken),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .wb_en       (writes_rd(wb_instr)),
        .wb_rd       (wb_instr[11:7]),
        .wb_data     (wb_result),
        .instr       (id_instr),
        .pc          (id_pc),
        .rs1_data    (id_rs1_data),
        .rs2_data    (id_rs2_data)
    );

    // rs1 is read by every valid opcode, so only rs2 needs a usage check.
    assign ex_rd    = ex_instr[11:7];
    assign load_use = ex_instr[6:0] == OP_LOAD && ex_rd != 5'd0 && is_valid(id_instr)
                      && (id_instr[19:15] == ex_rd
                          || (uses_rs2(id_instr[6:0]) && id_instr[24:20] == ex_rd));

    // Unsupported encodings are canonicalised to NOP on entry to EX.
    always_ff @(posedge clk_i) begin
        if (rst_i || br_taken || load_use) begin
            ex_instr    <= NOP;
            ex_pc       <= 32'd0;
            ex_rs1_data <= 32'd0;
            ex_rs2_data <= 32'd0;
        end else begin
            ex_instr    <= is_valid(id_instr) ? id_instr : NOP;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
        end
    end

    assign ex_op = ex_instr[6:0];
    assign ex_f3 = ex_instr[14:12];
    assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};
    assign imm_s = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
    assign imm_b = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7], ex_instr[30:25],
                    ex_instr[11:8], 1'b0};

    always_comb begin
        op_a = ex_rs1_data;
        if (writes_rd(mem_instr) && mem_instr[11:7] == ex_instr[19:15]) begin
            op_a = ex_alu_result;
        end else if (writes_rd(wb_instr) && wb_instr[11:7] == ex_instr[19:15]) begin
            op_a = wb_result;
        end
        op_b = ex_rs2_data;
        if (writes_rd(mem_instr) && mem_instr[11:7] == ex_instr[24:20]) begin
            op_b = ex_alu_result;
        end else if (writes_rd(wb_instr) && wb_instr[11:7] == ex_instr[24:20]) begin
            op_b = wb_result;
        end
    end

    always_comb begin
        alu_b   = (ex_op == OP_ALU) ? op_b : (ex_op == OP_STORE) ? imm_s : imm_i;
        alu_f3  = (ex_op == OP_LOAD || ex_op == OP_STORE) ? 3'b000 : ex_f3;
        alu_alt = (ex_op == OP_ALU || (ex_op == OP_ALU_I && ex_f3 == 3'b101)) && ex_instr[30];
        case (alu_f3)
            3'b000:  alu_res = alu_alt ? op_a - alu_b : op_a + alu_b;
            3'b001:  alu_res = op_a << alu_b[4:0];
            3'b010:  alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, op_a < alu_b};
            3'b100:  alu_res = op_a ^ alu_b;
            3'b101:  alu_res = alu_alt ? $unsigned($signed(op_a) >>> alu_b[4:0])
                                       : op_a >> alu_b[4:0];
            3'b110:  alu_res = op_a | alu_b;
            default: alu_res = op_a & alu_b;
        endcase
    end

    always_comb begin
        case (ex_f3)
            3'b000:  br_cond = op_a == op_b;
            3'b001:  br_cond = op_a != op_b;
            3'b100:  br_cond = $signed(op_a) < $signed(op_b);
            3'b101:  br_cond = $signed(op_a) >= $signed(op_b);
            3'b110:  br_cond = op_a < op_b;
            3'b111:  br_cond = op_a >= op_b;
            default: br_cond = 1'b0;
        endcase
        br_taken  = ex_op == OP_BRANCH && br_cond;
        br_target = ex_pc + imm_b;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_instr      <= NOP;
            ex_alu_result  <= 32'd0;
            mem_store_data <= 32'd0;
        end else begin
            mem_instr      <= ex_instr;
            ex_alu_result  <= alu_res;
            mem_store_data <= op_b;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) begin
                dmem[i] <= 32'd0;
            end
        end else if (mem_instr[6:0] == OP_STORE) begin
            dmem[ex_alu_result[9:2]] <= mem_store_data;
        end
    end

    assign load_data = dmem[ex_alu_result[9:2]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_instr  <= NOP;
            wb_result <= 32'd0;
        end else begin
            wb_instr  <= mem_instr;
            wb_result <= (mem_instr[6:0] == OP_LOAD) ? load_data : ex_alu_result;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: single-instruction vector table, hand-timed hazard sequences and
// random programs compared against an instruction-level reference model.

module tb_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_instr_en = 1'b0;
    logic [31:0] wr_instr = 32'd0;

    cpu dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_instr_en_i (wr_instr_en),
        .wr_instr_i    (wr_instr)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:63];
    logic [31:0] mr   [0:31];
    logic [31:0] mm   [0:255];

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    // Load prog[0:63] via the serial port, then reset so the next edge is edge 1.
    task automatic load_prog();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_instr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wr_instr = prog[i];
            tick();
        end
        wr_instr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = NOP;
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (a >> sh) | ((alt && a[31]) ? ~(32'hffff_ffff >> sh) : 32'd0);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Architectural reference: executes prog sequentially until it leaves the 64-word window.
    task automatic model_run();
        logic [31:0] ins, a, b, immi, imms, immb;
        logic [6:0]  op, f7;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        tk;
        int unsigned pc;
        for (int i = 0; i < 32; i++) mr[i] = 32'(i);
        for (int i = 0; i < 256; i++) mm[i] = 32'd0;
        pc = 0;
        for (int step = 0; step < 300 && pc < 256; step++) begin
            ins  = prog[pc / 4];
            op   = ins[6:0];
            rd   = ins[11:7];
            f3   = ins[14:12];
            f7   = ins[31:25];
            a    = mr[ins[19:15]];
            b    = mr[ins[24:20]];
            immi = {{20{ins[31]}}, ins[31:20]};
            imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            pc   = pc + 4;
            case (op)
                7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                           if (rd != 0) mr[rd] = ref_alu(f3, f7 == 7'h20, a, b);
                7'h13: if ((f3 == 3'd1 && f7 == 7'h00) ||
                           (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)) ||
                           (f3 != 3'd1 && f3 != 3'd5))
                           if (rd != 0) mr[rd] = ref_alu(f3, f3 == 3'd5 && f7 == 7'h20, a, immi);
                7'h03: if (rd != 0) mr[rd] = mm[((a + immi) / 4) % 256];
                7'h23: mm[((a + imms) / 4) % 256] = b;
                7'h63: begin
                    case (f3)
                        3'd0: tk = a == b;
                        3'd1: tk = a != b;
                        3'd4: tk = $signed(a) < $signed(b);
                        3'd5: tk = $signed(a) >= $signed(b);
                        3'd6: tk = a < b;
                        3'd7: tk = a >= b;
                        default: tk = 1'b0;
                    endcase
                    if (tk) pc = (pc - 4 + immb) % 1024;
                end
                default: ;
            endcase
        end
    endtask

    task automatic gen_prog();
        int k, rd, r1, r2, f3, f7, sh;
        clear_prog();
        for (int i = 0; i < 20; i++) begin
            k  = int'($urandom_range(0, 9));
            rd = int'($urandom_range(0, 7));
            r1 = int'($urandom_range(0, 7));
            r2 = int'($urandom_range(0, 7));
            f3 = int'($urandom_range(0, 7));
            sh = int'($urandom_range(0, 31));
            case (k)
                0, 1, 2: begin
                    f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0;
                    prog[i] = enc_r(f7, r2, r1, f3, rd);
                end
                3, 4: begin
                    if (f3 == 1) prog[i] = enc_i(sh, r1, 1, rd, 7'h13);
                    else if (f3 == 5) prog[i] = enc_i(($urandom_range(0, 1) == 1 ? 1024 : 0) + sh,
                                                      r1, 5, rd, 7'h13);
                    else prog[i] = enc_i(int'($urandom_range(0, 4095)), r1, f3, rd, 7'h13);
                end
                5: prog[i] = enc_i(4 * int'($urandom_range(0, 15)), 0, 2, rd, 7'h03);
                6: prog[i] = enc_s(4 * int'($urandom_range(0, 15)), r2, 0);
                7: begin
                    f3 = (f3 == 2) ? 0 : (f3 == 3) ? 1 : f3;
                    prog[i] = enc_b(4 * int'($urandom_range(1, 4)), r2, r1, f3);
                end
                8: prog[i] = ($urandom_range(0, 1) == 1) ? 32'hffff_ffff : enc_r(1, r2, r1, 0, rd);
                default: prog[i] = enc_i(-int'($urandom_range(1, 2047)), r1, 0, rd, 7'h13);
            endcase
        end
    endtask

    initial begin
        logic [31:0] w [0:2];

        // Fill the whole IMEM with NOPs so nothing stale sits past the program window.
        tick();
        rst = 1'b0;
        wr_instr_en = 1'b1;
        wr_instr = NOP;
        for (int i = 0; i < 256; i++) tick();
        wr_instr_en = 1'b0;

        vecs.push_back('{"add",   enc_r(0, 2, 1, 0, 3),            3,  32'd3});
        vecs.push_back('{"addi",  enc_i(7, 1, 0, 5, 7'h13),        5,  32'd8});
        vecs.push_back('{"addi-", enc_i(-2, 1, 0, 6, 7'h13),       6,  32'hffff_ffff});
        vecs.push_back('{"sub",   enc_r(32, 2, 1, 0, 7),           7,  32'hffff_ffff});
        vecs.push_back('{"sll",   enc_r(0, 2, 3, 1, 8),            8,  32'd12});
        vecs.push_back('{"slt",   enc_r(0, 5, 4, 2, 9),            9,  32'd1});
        vecs.push_back('{"sltu",  enc_r(0, 5, 6, 3, 10),           10, 32'd0});
        vecs.push_back('{"xor",   enc_r(0, 10, 12, 4, 11),         11, 32'd6});
        vecs.push_back('{"srl",   enc_r(0, 2, 31, 5, 12),          12, 32'd7});
        vecs.push_back('{"sra",   enc_r(32, 1, 31, 5, 13),         13, 32'd15});
        vecs.push_back('{"or",    enc_r(0, 6, 9, 6, 14),           14, 32'd15});
        vecs.push_back('{"and",   enc_r(0, 7, 13, 7, 15),          15, 32'd5});
        vecs.push_back('{"slti",  enc_i(-1, 3, 2, 16, 7'h13),      16, 32'd0});
        vecs.push_back('{"sltiu", enc_i(-1, 3, 3, 17, 7'h13),      17, 32'd1});
        vecs.push_back('{"xori",  enc_i(-1, 5, 4, 18, 7'h13),      18, 32'hffff_fffa});
        vecs.push_back('{"ori",   enc_i(3, 8, 6, 19, 7'h13),       19, 32'd11});
        vecs.push_back('{"andi",  enc_i(6, 15, 7, 20, 7'h13),      20, 32'd6});
        vecs.push_back('{"slli",  enc_i(31, 1, 1, 21, 7'h13),      21, 32'h8000_0000});
        vecs.push_back('{"srli",  enc_i(3, 30, 5, 22, 7'h13),      22, 32'd3});
        vecs.push_back('{"badop", 32'hffff_ffff,                   31, 32'd31});
        vecs.push_back('{"x0wr",  enc_r(0, 2, 1, 0, 0),            0,  32'd0});

        foreach (vecs[v]) begin
            clear_prog();
            prog[0] = vecs[v].instr;
            load_prog();
            for (int c = 0; c < 8; c++) tick();
            check(vecs[v].name, dut.id_stage.regs[vecs[v].rd], vecs[v].exp);
        end

        // Reset state and stage latency of a single add.
        clear_prog();
        prog[0] = enc_r(0, 4, 1, 0, 3);
        load_prog();
        check("rst_instr_r", dut.id_stage.instr_r, NOP);
        check("rst_alu", dut.ex_alu_result, 32'd0);
        check("rst_pc", dut.if_stage.pc, 32'd0);
        check("rst_fetch", dut.if_stage.instr_o, prog[0]);
        tick();
        check("e1_instr_r", dut.id_stage.instr_r, prog[0]);
        tick();
        check("e2_alu", dut.ex_alu_result, 32'd0);
        tick();
        check("e3_alu", dut.ex_alu_result, 32'd5);
        tick();
        check("e4_x3", dut.id_stage.regs[3], 32'd3);
        tick();
        check("e5_x3", dut.id_stage.regs[3], 32'd5);

        // Back-to-back forwarding, no stall.
        clear_prog();
        prog[0] = enc_i(10, 0, 0, 1, 7'h13);
        prog[1] = enc_r(0, 1, 1, 0, 2);
        prog[2] = enc_r(0, 1, 2, 0, 3);
        load_prog();
        for (int c = 0; c < 6; c++) tick();
        check("fwd_x3_e6", dut.id_stage.regs[3], 32'd3);
        tick();
        check("fwd_x2", dut.id_stage.regs[2], 32'd20);
        check("fwd_x3_e7", dut.id_stage.regs[3], 32'd30);

        // Taken branch flushes two younger instructions.
        clear_prog();
        prog[0] = enc_b(8, 1, 1, 0);
        prog[1] = enc_i(1, 0, 0, 10, 7'h13);
        prog[2] = enc_i(5, 0, 0, 11, 7'h13);
        load_prog();
        for (int c = 0; c < 3; c++) tick();
        check("br_flush_id", dut.id_stage.instr_r, NOP);
        tick();
        check("br_flush_ex", dut.ex_alu_result, 32'd0);
        for (int c = 0; c < 3; c++) tick();
        check("br_x11_e7", dut.id_stage.regs[11], 32'd11);
        tick();
        check("br_x11_e8", dut.id_stage.regs[11], 32'd5);
        check("br_x10", dut.id_stage.regs[10], 32'd10);

        // Store, load, load-use with one bubble.
        clear_prog();
        prog[0] = enc_s(4, 5, 0);
        prog[1] = enc_i(4, 0, 2, 8, 7'h03);
        prog[2] = enc_r(0, 8, 8, 0, 9);
        load_prog();
        for (int c = 0; c < 7; c++) tick();
        check("lu_x9_e7", dut.id_stage.regs[9], 32'd9);
        tick();
        check("lu_x9_e8", dut.id_stage.regs[9], 32'd10);
        check("lu_x8", dut.id_stage.regs[8], 32'd5);
        check("lu_dmem", dut.dmem[1], 32'd5);

        // Mid-run reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_pc", dut.if_stage.pc, 32'd0);
        check("mr_instr_r", dut.id_stage.instr_r, NOP);
        check("mr_alu", dut.ex_alu_result, 32'd0);
        check("mr_dmem", dut.dmem[1], 32'd0);
        for (int i = 0; i < 32; i++) check($sformatf("mr_x%0d", i), dut.id_stage.regs[i], 32'(i));

        // Serial load port; a same-cycle write and fetch of word 0 returns the old word.
        w[0] = 32'hdead_beef;
        w[1] = 32'h1234_5678;
        w[2] = 32'hcafe_f00d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_instr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_instr = w[i];
            if (i == 0) check("ld_old_word", dut.if_stage.instr_o, prog[0]);
            tick();
        end
        wr_instr_en = 1'b0;
        for (int i = 0; i < 3; i++)
            check($sformatf("ld_cache%0d", i), dut.if_stage.instr_cache.cache_c[i], w[i]);

        // Random programs against the reference model.
        for (int p = 0; p < 8; p++) begin
            gen_prog();
            model_run();
            load_prog();
            for (int c = 0; c < 150; c++) tick();
            for (int i = 0; i < 32; i++)
                check($sformatf("rnd%0d_x%0d", p, i), dut.id_stage.regs[i], mr[i]);
            for (int i = 0; i < 16; i++)
                check($sformatf("rnd%0d_m%0d", p, i), dut.dmem[i], mm[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
